// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: buttons to run/pause/clear/adjust actions
// for a 4-digit BCD counter chain, with terminal preset detection.
module stopwatch_ctrl #(
  parameter logic [15:0] PRESET_LO = 16'h1020,
  parameter logic [15:0] PRESET_HI = 16'h4030,
  parameter logic [7:0]  MIN_LO    = 8'h10,
  parameter logic [7:0]  MIN_HI    = 8'h49
) (
  input  logic        clk_in,
  input  logic        RESET,
  input  logic        START,
  input  logic        CLEAR,
  input  logic        REVERSE,
  input  logic        ADD,
  input  logic        SUBTRACT,
  input  logic        TICK,
  input  logic [15:0] Q,
  output logic        CNT_EN,
  output logic        DIR,
  output logic        LOAD,
  output logic [15:0] LOAD_VALUE,
  output logic        DONE,
  output logic [1:0]  STATE
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t      state;
  logic        dir_r;
  logic        load_r;
  logic        done_r;
  logic [15:0] lv_r;
  logic        init_pend;

  logic start_q;
  logic clear_q;
  logic add_q;
  logic sub_q;

  logic start_e;
  logic clear_e;
  logic add_e;
  logic sub_e;

  logic        term;
  logic        adj_ok;
  logic [7:0]  m;
  logic [7:0]  m_next;
  logic [15:0] adj_val;

  function automatic logic [7:0] bcd_inc(
    input logic [7:0] v
  );
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(
    input logic [7:0] v
  );
    if (v[3:0] == 4'd0)
      return {v[7:4] - 4'd1, 4'd9};
    else
      return {v[7:4], v[3:0] - 4'd1};
  endfunction

  function automatic logic [15:0] preset(
    input logic d
  );
    return d ? PRESET_HI : PRESET_LO;
  endfunction

  assign start_e = START    & ~start_q;
  assign clear_e = CLEAR    & ~clear_q;
  assign add_e   = ADD      & ~add_q;
  assign sub_e   = SUBTRACT & ~sub_q;

  // BCD digit order keeps plain unsigned compare meaningful
  assign term = dir_r ? (Q <= PRESET_LO)
                      : (Q >= PRESET_HI);

  assign CNT_EN = (state == S_RUN) & TICK & ~term;

  assign m = Q[15:8];

  always_comb begin
    adj_ok = 1'b0;
    m_next = m;
    if (add_e && !sub_e && m != MIN_HI) begin
      adj_ok = 1'b1;
      m_next = bcd_inc(m);
    end else if (sub_e && !add_e && m != MIN_LO) begin
      adj_ok = 1'b1;
      m_next = bcd_dec(m);
    end
  end

  assign adj_val = {m_next, Q[7:0]};

  always_ff @(posedge clk_in) begin
    if (RESET) begin
      state     <= S_IDLE;
      dir_r     <= 1'b0;
      load_r    <= 1'b0;
      lv_r      <= 16'h0000;
      done_r    <= 1'b0;
      init_pend <= 1'b1;
      start_q   <= 1'b0;
      clear_q   <= 1'b0;
      add_q     <= 1'b0;
      sub_q     <= 1'b0;
    end else begin
      start_q   <= START;
      clear_q   <= CLEAR;
      add_q     <= ADD;
      sub_q     <= SUBTRACT;
      load_r    <= 1'b0;
      init_pend <= 1'b0;
      if (clear_e) begin
        state  <= S_IDLE;
        dir_r  <= REVERSE;
        load_r <= 1'b1;
        lv_r   <= preset(REVERSE);
        done_r <= 1'b0;
      end else if (state == S_RUN && term) begin
        state  <= S_DONE;
        done_r <= 1'b1;
      end else begin
        unique case (state)
          S_IDLE: begin
            // direction change or init load wins over adjust
            if (REVERSE != dir_r) begin
              dir_r  <= REVERSE;
              load_r <= 1'b1;
              lv_r   <= preset(REVERSE);
            end else if (init_pend) begin
              load_r <= 1'b1;
              lv_r   <= preset(dir_r);
            end else if (!start_e && adj_ok) begin
              load_r <= 1'b1;
              lv_r   <= adj_val;
            end
            if (start_e)
              state <= S_RUN;
          end
          S_RUN: begin
            if (start_e)
              state <= S_PAUSE;
          end
          S_PAUSE: begin
            if (start_e) begin
              state <= S_RUN;
            end else if (adj_ok) begin
              load_r <= 1'b1;
              lv_r   <= adj_val;
            end
          end
          S_DONE: begin
            state <= S_DONE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign DIR        = dir_r;
  assign LOAD       = load_r;
  assign LOAD_VALUE = lv_r;
  assign DONE       = done_r;
  assign STATE      = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Table-driven bench for stopwatch_ctrl with an expected-output queue.
module tb_stopwatch_ctrl;

  logic        clk_in;
  logic        RESET;
  logic        START;
  logic        CLEAR;
  logic        REVERSE;
  logic        ADD;
  logic        SUBTRACT;
  logic        TICK;
  logic [15:0] Q;
  logic        CNT_EN;
  logic        DIR;
  logic        LOAD;
  logic [15:0] LOAD_VALUE;
  logic        DONE;
  logic [1:0]  STATE;

  stopwatch_ctrl dut (
    .clk_in     (clk_in),
    .RESET      (RESET),
    .START      (START),
    .CLEAR      (CLEAR),
    .REVERSE    (REVERSE),
    .ADD        (ADD),
    .SUBTRACT   (SUBTRACT),
    .TICK       (TICK),
    .Q          (Q),
    .CNT_EN     (CNT_EN),
    .DIR        (DIR),
    .LOAD       (LOAD),
    .LOAD_VALUE (LOAD_VALUE),
    .DONE       (DONE),
    .STATE      (STATE)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        rst, st, cl, rv, ad, sb, tk;
    logic [15:0] q;
    logic        cen;
    logic [1:0]  s;
    logic        d, ld;
    logic [15:0] lv;
    logic        dn;
  } vec_t;

  typedef struct {
    logic [1:0]  s;
    logic        d, ld;
    logic [15:0] lv;
    logic        dn;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_chk;
  int   n_fail;

  function automatic vec_t mk(
    input logic rst, st, cl, rv, ad, sb, tk,
    input logic [15:0] q,
    input logic cen,
    input logic [1:0] s,
    input logic d, ld,
    input logic [15:0] lv,
    input logic dn
  );
    vec_t v;
    v.rst = rst; v.st = st; v.cl = cl; v.rv = rv;
    v.ad = ad; v.sb = sb; v.tk = tk; v.q = q;
    v.cen = cen; v.s = s; v.d = d; v.ld = ld;
    v.lv = lv; v.dn = dn;
    return v;
  endfunction

  task automatic chk(
    input string nm,
    input logic [15:0] act,
    input logic [15:0] exp,
    input int idx
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %h want %h",
               nm, idx, act, exp);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        v;
    exp_t        e;
    exp_t        g;
    logic [15:0] hold;

    n_chk  = 0;
    n_fail = 0;
    hold   = 16'h0000;

    // reset and init load
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1,0,0,0,0,0,0,16'h0000,0, 0,0,0,16'h0000,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,16'h0000,0, 0,0,1,16'h1020,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,16'h1020,0, 0,0,0,16'h0000,0));
    // up-run to terminal
    vecs.push_back(mk(0,1,0,0,0,0,0,16'h1020,0, 1,0,0,16'h0000,0));
    vecs.push_back(mk(0,1,0,0,0,0,1,16'h1020,1, 1,0,0,16'h0000,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,16'h1020,0, 1,0,0,16'h0000,0));
    vecs.push_back(mk(0,0,0,0,0,0,1,16'h1021,1, 1,0,0,16'h0000,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,16'h4030,0, 3,0,0,16'h0000,1));
    vecs.push_back(mk(0,0,0,0,0,0,1,16'h4030,0, 3,0,0,16'h0000,1));
    vecs.push_back(mk(0,1,0,0,0,0,0,16'h4030,0, 3,0,0,16'h0000,1));
    vecs.push_back(mk(0,0,1,0,0,0,0,16'h4030,0, 0,0,1,16'h1020,0));
    // pause / resume
    vecs.push_back(mk(0,1,0,0,0,0,0,16'h1020,0, 1,0,0,16'h0000,0));
    vecs.push_back(mk(0,0,0,0,0,0,1,16'h1100,1, 1,0,0,16'h0000,0));
    vecs.push_back(mk(0,1,0,0,0,0,0,16'h1100,0, 2,0,0,16'h0000,0));
    vecs.push_back(mk(0,1,0,0,0,0,1,16'h1100,0, 2,0,0,16'h0000,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,16'h1100,0, 2,0,0,16'h0000,0));
    vecs.push_back(mk(0,1,0,0,0,0,0,16'h1100,0, 1,0,0,16'h0000,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,16'h1100,0, 1,0,0,16'h0000,0));
    vecs.push_back(mk(0,1,0,0,0,0,0,16'h1100,0, 2,0,0,16'h0000,0));
    // minute adjust in PAUSED
    vecs.push_back(mk(0,0,0,0,1,0,0,16'h1959,0, 2,0,1,16'h2059,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,16'h2000,0, 2,0,0,16'h0000,0));
    vecs.push_back(mk(0,0,0,0,0,1,0,16'h2000,0, 2,0,1,16'h1900,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,16'h4912,0, 2,0,0,16'h0000,0));
    vecs.push_back(mk(0,0,0,0,1,0,0,16'h4912,0, 2,0,0,16'h0000,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,16'h1012,0, 2,0,0,16'h0000,0));
    vecs.push_back(mk(0,0,0,0,0,1,0,16'h1012,0, 2,0,0,16'h0000,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,16'h2000,0, 2,0,0,16'h0000,0));
    vecs.push_back(mk(0,0,0,0,1,1,0,16'h2000,0, 2,0,0,16'h0000,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,16'h3912,0, 2,0,0,16'h0000,0));
    vecs.push_back(mk(0,0,0,0,1,0,0,16'h3912,0, 2,0,1,16'h4012,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,16'h3912,0, 2,0,0,16'h0000,0));
    // direction change and down-run
    vecs.push_back(mk(0,0,1,0,0,0,0,16'h3912,0, 0,0,1,16'h1020,0));
    vecs.push_back(mk(0,0,0,1,0,0,0,16'h1020,0, 0,1,1,16'h4030,0));
    vecs.push_back(mk(0,0,0,1,0,0,0,16'h4030,0, 0,1,0,16'h0000,0));
    vecs.push_back(mk(0,1,0,1,0,0,0,16'h4030,0, 1,1,0,16'h0000,0));
    vecs.push_back(mk(0,0,0,1,0,0,1,16'h4030,1, 1,1,0,16'h0000,0));
    vecs.push_back(mk(0,0,0,1,0,0,0,16'h1020,0, 3,1,0,16'h0000,1));
    vecs.push_back(mk(0,0,1,1,0,0,0,16'h1020,0, 0,1,1,16'h4030,0));
    vecs.push_back(mk(0,1,0,1,0,0,0,16'h4030,0, 1,1,0,16'h0000,0));
    vecs.push_back(mk(0,0,0,1,0,0,1,16'h3000,1, 1,1,0,16'h0000,0));
    vecs.push_back(mk(0,1,1,1,0,0,0,16'h3000,0, 0,1,1,16'h4030,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,16'h1020,0, 0,0,1,16'h1020,0));
    // overshoot past terminal after adjust
    vecs.push_back(mk(0,1,0,0,0,0,0,16'h1020,0, 1,0,0,16'h0000,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,16'h1020,0, 1,0,0,16'h0000,0));
    vecs.push_back(mk(0,1,0,0,0,0,0,16'h1020,0, 2,0,0,16'h0000,0));
    vecs.push_back(mk(0,0,0,0,1,0,0,16'h4030,0, 2,0,1,16'h4130,0));
    vecs.push_back(mk(0,1,0,0,0,0,0,16'h4130,0, 1,0,0,16'h0000,0));
    vecs.push_back(mk(0,0,0,0,0,0,1,16'h4130,0, 3,0,0,16'h0000,1));
    // reset in the cycle of an ADD edge while paused
    vecs.push_back(mk(0,0,1,0,0,0,0,16'h4130,0, 0,0,1,16'h1020,0));
    vecs.push_back(mk(0,1,0,0,0,0,0,16'h1020,0, 1,0,0,16'h0000,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,16'h1020,0, 1,0,0,16'h0000,0));
    vecs.push_back(mk(0,1,0,0,0,0,0,16'h1020,0, 2,0,0,16'h0000,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,16'h1500,0, 2,0,0,16'h0000,0));
    vecs.push_back(mk(1,0,0,0,1,0,0,16'h1500,0, 0,0,0,16'h0000,0));
    vecs.push_back(mk(1,0,0,0,1,0,0,16'h1500,0, 0,0,0,16'h0000,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,16'h1500,0, 0,0,1,16'h1020,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,16'h1020,0, 0,0,0,16'h0000,0));

    RESET = 1'b1; START = 1'b0; CLEAR = 1'b0;
    REVERSE = 1'b0; ADD = 1'b0; SUBTRACT = 1'b0;
    TICK = 1'b0; Q = 16'h0000;
    @(posedge clk_in);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      RESET    = v.rst;
      START    = v.st;
      CLEAR    = v.cl;
      REVERSE  = v.rv;
      ADD      = v.ad;
      SUBTRACT = v.sb;
      TICK     = v.tk;
      Q        = v.q;
      #2;
      chk("cnt_en", {15'd0, CNT_EN}, {15'd0, v.cen}, i);
      if (v.rst)
        hold = 16'h0000;
      else if (v.ld)
        hold = v.lv;
      e.s  = v.s;
      e.d  = v.d;
      e.ld = v.ld;
      e.lv = hold;
      e.dn = v.dn;
      sb_q.push_back(e);
      @(posedge clk_in);
      #1;
      g = sb_q.pop_front();
      chk("state", {14'd0, STATE}, {14'd0, g.s}, i);
      chk("dir", {15'd0, DIR}, {15'd0, g.d}, i);
      chk("load", {15'd0, LOAD}, {15'd0, g.ld}, i);
      chk("load_value", LOAD_VALUE, g.lv, i);
      chk("done", {15'd0, DONE}, {15'd0, g.dn}, i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control FSM that sequences the 4-digit BCD stopwatch counter chain (digits: sec units 0-9, sec tens 0-5, min units 0-9, min tens 1-4). It turns operator buttons into run/pause/clear/adjust actions and drives the count enable, direction, and parallel-load strobe and value. It also detects the terminal preset and stops the chain there. It sits between the debounced buttons, the tick generator, and the counter chain.

Parameters:
PRESET_LO, 16'h1020, BCD start value for up-count and terminal value for down-count
PRESET_HI, 16'h4030, BCD start value for down-count and terminal value for up-count
MIN_LO, 8'h10, lowest minutes value reachable by SUBTRACT (BCD)
MIN_HI, 8'h49, highest minutes value reachable by ADD (BCD)

Ports:
clk_in  in  1  system clock; all state updates on rising edge
RESET  in  1  synchronous, active-high; highest priority
START  in  1  debounced level; rising edge toggles run/pause
CLEAR  in  1  debounced level; rising edge reloads the start preset
REVERSE  in  1  level; 0 = up-count, 1 = down-count; honoured only in IDLE
ADD  in  1  debounced level; rising edge adds +1 minute
SUBTRACT  in  1  debounced level; rising edge applies -1 minute
TICK  in  1  one-cycle count pulse from the tick generator
Q  in  16  current BCD counter value, {min tens, min units, sec tens, sec units}
CNT_EN  out  1  counter-chain enable (combinational)
DIR  out  1  registered direction to the counters
LOAD  out  1  one-cycle parallel-load strobe (registered)
LOAD_VALUE  out  16  BCD value to load; valid when LOAD=1
DONE  out  1  high while in state DONE
STATE  out  2  IDLE=00, RUNNING=01, PAUSED=10, DONE=11

Behaviour:
- Edge detection: one register per button (START, CLEAR, ADD, SUBTRACT). An edge occurs in cycle n when the input is 1 at n and was 0 at n-1. The edge registers clear to 0 on RESET.
- Reset values while RESET=1: STATE=IDLE, DIR=0, LOAD=0, LOAD_VALUE=16'h0000, DONE=0, CNT_EN=0. An internal init_pend flag is set to 1.
- First cycle after RESET deasserts: init_pend causes LOAD=1 in the next cycle, with LOAD_VALUE = DIR ? PRESET_HI : PRESET_LO. init_pend then clears.
- term = DIR ? (Q <= PRESET_LO) : (Q >= PRESET_HI), using an unsigned 16-bit compare (valid because BCD ordering is preserved).
- CNT_EN = (STATE==RUNNING) & TICK & ~term.
- Priority within a cycle: RESET > CLEAR edge > term (RUNNING only) > START edge > ADD/SUBTRACT edge.
- CLEAR edge (any state):
  - STATE becomes IDLE.
  - DIR is set to REVERSE.
  - Next cycle: LOAD=1, LOAD_VALUE = REVERSE ? PRESET_HI : PRESET_LO.
- IDLE:
  - If REVERSE != DIR: DIR is set to REVERSE and the new start preset loads next cycle. This counts as a LOAD event; an ADD/SUB in the same cycle is dropped.
  - START edge → RUNNING.
- RUNNING:
  - If term → DONE, regardless of any START edge in the same cycle.
  - Else START edge → PAUSED.
  - ADD, SUBTRACT and REVERSE are ignored.
- PAUSED: START edge → RUNNING.
- DONE:
  - START, ADD and SUBTRACT are ignored.
  - Exits only via CLEAR or RESET.
- ADD/SUBTRACT, accepted in IDLE and PAUSED only:
  - If both edges occur in the same cycle, it is a no-op.
  - Minutes m = Q[15:8] in BCD.
  - ADD: units 9 wraps to 0 with a carry into tens. If m == MIN_HI, no change and no LOAD.
  - SUBTRACT: units 0 wraps to 9 with a borrow from tens. If m == MIN_LO, no change and no LOAD.
  - Otherwise LOAD=1 in the next cycle with LOAD_VALUE = {m', Q[7:0]}. Seconds are preserved.
- Latency: every action edge seen in cycle n gives STATE/LOAD/DIR in cycle n+1. LOAD is high for exactly 1 cycle.
- Overshoot: an adjusted value may lie past the terminal preset. term is then already true, so RUNNING goes to DONE on the first cycle and no TICK is passed.
- Outputs other than CNT_EN are registered. LOAD_VALUE holds its last value when LOAD=0.

Test Plan:
- Reset and init: RESET 3 cycles, then release, REVERSE=0 → LOAD pulses once with 16'h1020; STATE=00, DIR=0.
- Up-run to terminal: START edge, Q=16'h1020, TICK every 4 cycles → CNT_EN follows TICK. Force Q=16'h4030 → next cycle STATE=11, DONE=1, CNT_EN=0 even with TICK=1. START edge in DONE → no change.
- Pause/resume: in RUNNING, START edge → STATE=10 and CNT_EN=0 under TICK. START again → 01.
- Minute adjust in PAUSED, Q=16'h1959:
  - ADD → LOAD_VALUE=16'h2059.
  - Q=16'h2000, SUBTRACT → 16'h1900.
  - Q=16'h4912, ADD → no LOAD.
  - Q=16'h1012, SUBTRACT → no LOAD.
  - ADD and SUBTRACT in the same cycle → no LOAD.
- Direction and clear: in IDLE, REVERSE 0→1 → next cycle DIR=1, LOAD with 16'h4030. Down-run reaching Q=16'h1020 → DONE. CLEAR edge in RUNNING with a simultaneous START edge → IDLE and LOAD with 16'h4030.
- RESET mid-operation: RESET asserted in the cycle of an ADD edge while PAUSED → no LOAD in that cycle or the next. Outputs at their reset values. Init LOAD fires after release.
